mem_port_arbiter: RTL

- Shares one single-port unified memory between the pipeline's instruction-fetch port (pc_out/ir) and data port (alu_DMEM/writedata_DMEM/memwrite_MEM/readdata_MEM).
- Fixed priority is data over fetch, with a fetch starvation limit. Generates the core stall.
- Sits between the pipeline top and the memory macro or bus bridge. One transaction outstanding at a time.

---
 rtl/memarb_pkg.sv | 14 +
 rtl/memarb_fetch_buf.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/memarb_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package memarb_pkg;

    localparam int unsigned ADDR_W_DEFAULT     = 32;
    localparam int unsigned DATA_W_DEFAULT     = 32;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/memarb_fetch_buf.sv
// One-entry fetch buffer: remembers the last completed, unflushed fetch so a
// repeated fetch of the same word can be served without a memory access.
module memarb_fetch_buf
    import memarb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_tag,
    input  logic [DATA_W-1:0] load_data,
    input  logic              inv_req,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    // Load on fetch completion; a store to the buffered word makes it stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            tag_q   <= load_tag;
            data_q  <= load_data;
        end else if (inv_req && (inv_addr == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit  = valid_q && (lookup_addr == tag_q);
    assign data = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data has priority; a fetch is forced through after STARVE_MAX back-to-back
// data grants. One memory transaction is outstanding at a time.
// Define MEMARB_FETCH_BUF_EN to add a one-entry fetch buffer (memarb_fetch_buf).
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              core_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic              flush_pend_q;

    logic              if_pend;
    logic              d_pend;
    logic              grant_d;
    logic              grant_i;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

    // A requester still holding its request during its own ready pulse is stale.
    assign if_pend = if_req & ~if_ready;
    assign d_pend  = (d_read | d_write) & ~d_ready;

    assign grant_d = (state_q == StIdle) & d_pend &
                     ~(if_pend & ~buf_hit & (starve_cnt_q == STARVE_LIM));
    assign grant_i = (state_q == StIdle) & if_pend & ~buf_hit & ~grant_d;

    assign core_stall = (if_req & ~if_ready) | ((d_read | d_write) & ~d_ready);

`ifdef MEMARB_FETCH_BUF_EN
    logic buf_load;
    logic buf_match;

    assign buf_load = (state_q == StBusyI) & mem_ack & ~flush_pend_q & ~if_flush;

    memarb_fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .load_tag    (mem_addr),
        .load_data   (mem_rdata),
        .inv_req     (grant_d & d_write),
        .inv_addr    (d_addr),
        .lookup_addr (if_addr),
        .hit         (buf_match),
        .data        (buf_data)
    );

    // A hit is served from the buffer and may coexist with a data grant.
    assign buf_hit = (state_q == StIdle) & if_pend & buf_match;
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // Arbiter FSM with registered memory-side and core-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            flush_pend_q <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_ready     <= 1'b0;
            if_rdata     <= '0;
            d_ready      <= 1'b0;
            d_rdata      <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            if (!if_req || grant_i || buf_hit) begin
                starve_cnt_q <= '0;
            end else if (grant_d && (starve_cnt_q != STARVE_LIM)) begin
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (buf_hit) begin
                        if_ready <= 1'b1;
                        if_rdata <= buf_data;
                    end
                    if (grant_d) begin
                        state_q   <= StBusyD;
                        mem_req   <= 1'b1;
                        mem_we    <= d_write;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state_q      <= StBusyI;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        mem_wdata    <= '0;
                        flush_pend_q <= if_flush;
                    end
                end
                StBusyI: begin
                    if (if_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        state_q      <= StIdle;
                        mem_req      <= 1'b0;
                        flush_pend_q <= 1'b0;
                        // A flushed fetch finishes on the memory side only.
                        if (!(flush_pend_q || if_flush)) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                StBusyD: begin
                    if (mem_ack) begin
                        state_q <= StIdle;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
